// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the pre-IF fetch sequencer: FSM encoding,
// default reset PC and sequential PC increment.
package fetch_ctrl_pkg;

  typedef enum logic [0:0] {
    FS_REQ  = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_ctrl_chk.sv
// Protocol checker: the SRAM must never return data while no fetch is outstanding.
module fetch_ctrl_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_in_wait,
  input logic i_data_ok
);

  a_no_data_ok_in_req: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_data_ok && !i_in_wait));

endmodule

// File: rtl/fetch_out_buf.sv
// Single-entry instruction buffer between the fetch sequencer and IF.
// Kill beats fill, fill beats consume.
module fetch_out_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_pc,
  input  logic [31:0]       i_fill_inst,
  input  logic              i_consume,
  input  logic              i_kill,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;

  // Buffer entry update: pc/inst keep their last value when the entry is killed or drained.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= 32'h0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_pc    <= i_fill_pc;
      r_inst  <= i_fill_inst;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one SRAM fetch outstanding,
// applies branch redirects and drops wrong-path responses.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_if_allow_in,
  output logic              o_inst_sram_req,
  output logic [ADDR_W-1:0] o_inst_sram_addr,
  input  logic              i_inst_sram_addr_ok,
  input  logic              i_inst_sram_data_ok,
  input  logic [31:0]       i_inst_sram_rdata,
  output logic              o_if_valid,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [31:0]       o_if_inst
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_cancel;
  logic              w_req;
  logic              w_accept;
  logic              w_resp;
  logic              w_fill;
  logic              w_consume;
  logic              w_buf_valid;

  assign w_consume = w_buf_valid & i_if_allow_in;
  assign w_accept  = w_req & i_inst_sram_addr_ok;
  assign w_resp    = (r_state == FS_WAIT) & i_inst_sram_data_ok;
  assign w_fill    = w_resp & ~r_cancel & ~i_br_taken;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FS_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_REQ: begin
        if (w_accept) w_state_nxt = FS_WAIT;
        else          w_state_nxt = FS_REQ;
      end
      FS_WAIT: begin
        if (i_inst_sram_data_ok) w_state_nxt = FS_REQ;
        else                     w_state_nxt = FS_WAIT;
      end
      default: w_state_nxt = FS_REQ;
    endcase
  end

  // FSM outputs: a request is only raised when the buffer is empty or draining this cycle.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      FS_REQ:  w_req = ~i_rst & (~w_buf_valid | w_consume);
      FS_WAIT: w_req = 1'b0;
      default: w_req = 1'b0;
    endcase
  end

  // PC bookkeeping and wrong-path cancel flag; a redirect always wins for fetch_pc.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_cancel   <= 1'b0;
    end else begin
      if (i_br_taken) begin
        r_fetch_pc <= i_br_target;
      end else if (w_fill) begin
        r_fetch_pc <= r_req_pc + ADDR_W'(PC_INCR);
      end else begin
        r_fetch_pc <= r_fetch_pc;
      end

      if (w_accept) begin
        r_req_pc <= r_fetch_pc;
      end else begin
        r_req_pc <= r_req_pc;
      end

      if (w_resp) begin
        r_cancel <= 1'b0;
      end else if (i_br_taken && ((r_state == FS_WAIT) || w_accept)) begin
        r_cancel <= 1'b1;
      end else begin
        r_cancel <= r_cancel;
      end
    end
  end

  fetch_out_buf #(.ADDR_W(ADDR_W)) u_out_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_fill      (w_fill),
    .i_fill_pc   (r_req_pc),
    .i_fill_inst (i_inst_sram_rdata),
    .i_consume   (w_consume),
    .i_kill      (i_br_taken),
    .o_valid     (w_buf_valid),
    .o_pc        (o_if_pc),
    .o_inst      (o_if_inst)
  );

  fetch_ctrl_chk u_chk (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_in_wait (r_state == FS_WAIT),
    .i_data_ok (i_inst_sram_data_ok)
  );

  assign o_inst_sram_req  = w_req;
  assign o_inst_sram_addr = r_fetch_pc;
  assign o_if_valid       = w_buf_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model (queue of outstanding
// fetches tagged live/dead, plus the IF buffer) is compared every cycle.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        if_allow_in = 1'b0;
  logic        sram_req;
  logic [31:0] sram_addr;
  logic        sram_addr_ok = 1'b0;
  logic        sram_data_ok = 1'b0;
  logic [31:0] sram_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int errors = 0;
  int checks = 0;

  // Model: next fetch address, outstanding fetches {live, pc}, IF buffer.
  logic [31:0] m_next_pc   = 32'h1c00_0000;
  logic        m_buf_valid = 1'b0;
  logic [31:0] m_buf_pc    = 32'h0;
  logic [31:0] m_buf_inst  = 32'h0;
  logic [32:0] m_q[$];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_br_taken          (br_taken),
    .i_br_target         (br_target),
    .i_if_allow_in       (if_allow_in),
    .o_inst_sram_req     (sram_req),
    .o_inst_sram_addr    (sram_addr),
    .i_inst_sram_addr_ok (sram_addr_ok),
    .i_inst_sram_data_ok (sram_data_ok),
    .i_inst_sram_rdata   (sram_rdata),
    .o_if_valid          (if_valid),
    .o_if_pc             (if_pc),
    .o_if_inst           (if_inst)
  );

  function automatic logic [31:0] mem(input logic [31:0] pc);
    return pc ^ 32'h5a5a_a5a5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model at the edge.
  task automatic step(input logic s_rst, input logic s_br, input logic [31:0] s_tgt,
                      input logic s_allow, input logic s_aok, input logic s_dok);
    logic        e_req;
    logic        consume;
    logic        resp;
    logic [32:0] ent;
    @(negedge clk);
    rst          = s_rst;
    br_taken     = s_br;
    br_target    = s_tgt;
    if_allow_in  = s_allow;
    sram_addr_ok = s_aok;
    resp         = s_dok && !s_rst && (m_q.size() > 0);
    sram_data_ok = resp;
    sram_rdata   = resp ? mem(m_q[0][31:0]) : 32'h0;
    consume      = m_buf_valid && s_allow;
    e_req        = !s_rst && (m_q.size() == 0) && (!m_buf_valid || consume);
    #1;
    chk("req", {31'd0, sram_req}, {31'd0, e_req});
    if (e_req) chk("addr", sram_addr, m_next_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_buf_valid});
    if (m_buf_valid) begin
      chk("if_pc", if_pc, m_buf_pc);
      chk("if_inst", if_inst, m_buf_inst);
    end
    @(posedge clk);
    if (s_rst) begin
      m_next_pc   = 32'h1c00_0000;
      m_buf_valid = 1'b0;
      m_buf_pc    = 32'h0;
      m_buf_inst  = 32'h0;
      m_q.delete();
    end else begin
      if (consume) m_buf_valid = 1'b0;
      if (resp) begin
        ent = m_q.pop_front();
        if (ent[32] && !s_br) begin
          m_buf_valid = 1'b1;
          m_buf_pc    = ent[31:0];
          m_buf_inst  = mem(ent[31:0]);
          m_next_pc   = ent[31:0] + 32'd4;
        end
      end
      if (e_req && s_aok) m_q.push_back({1'b1, m_next_pc});
      if (s_br) begin
        m_next_pc   = s_tgt;
        m_buf_valid = 1'b0;
        foreach (m_q[i]) m_q[i][32] = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", sram_addr, 32'h1c00_0000);

    // Zero-wait SRAM, IF always accepting.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("first_valid", {31'd0, if_valid}, 32'h1);
    chk("first_pc", if_pc, 32'h1c00_0000);
    chk("second_addr", sram_addr, 32'h1c00_0004);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // IF stalled: buffer holds, no new request.
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("stall_valid", {31'd0, if_valid}, 32'h1);
    chk("stall_pc", if_pc, 32'h1c00_0004);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Redirect while waiting for data.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1c00_0100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_wait_valid", {31'd0, if_valid}, 32'h0);
    chk("br_wait_addr", sram_addr, 32'h1c00_0100);

    // Redirect coincident with addr_ok.
    step(1'b0, 1'b1, 32'h1c00_0200, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_aok_valid", {31'd0, if_valid}, 32'h0);
    chk("br_aok_addr", sram_addr, 32'h1c00_0200);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Redirect kills a held buffered instruction.
    step(1'b0, 1'b1, 32'h1c00_0300, 1'b0, 1'b1, 1'b0);
    #1;
    chk("kill_valid", {31'd0, if_valid}, 32'h0);
    chk("kill_addr", sram_addr, 32'h1c00_0300);

    // Redirect coincident with data_ok.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1c00_0400, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_dok_valid", {31'd0, if_valid}, 32'h0);
    chk("br_dok_addr", sram_addr, 32'h1c00_0400);

    // Back-to-back redirects, second one on the cancelled response.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1c00_0500, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h1c00_0600, 1'b1, 1'b0, 1'b1);
    #1;
    chk("b2b_addr", sram_addr, 32'h1c00_0600);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("b2b_pc", if_pc, 32'h1c00_0600);

    // PC wraps modulo 2^32.
    step(1'b0, 1'b1, 32'hffff_fffc, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("wrap_pc", if_pc, 32'hffff_fffc);
    chk("wrap_addr", sram_addr, 32'h0);

    // Reset while a fetch is outstanding.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_wait_valid", {31'd0, if_valid}, 32'h0);
    chk("rst_wait_addr", sram_addr, 32'h1c00_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Mixed handshake timing with occasional redirects.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (i % 11) == 7, 32'h1c00_1000 + 32'(i) * 32'd16,
           (i % 3) != 0, (i % 4) != 1, (i % 5) != 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Pre-IF sequencer that owns the fetch PC and drives the instruction SRAM request/response handshake (req/addr_ok/data_ok).
- Holds exactly one outstanding fetch and buffers one returned instruction for the IF stage.
- Applies branch redirects and discards responses from the wrong path.
- Sits between the branch-resolution logic (ID/EX) and the IF pipeline register; it replaces free-running PC+4 stepping with a handshake-correct controller.

Parameters:
- RESET_PC, 32'h1c000000: first fetch address after reset.
- ADDR_W, 32: PC/address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- br_taken  in  1  redirect strobe, one cycle per resolved taken branch/jump.
- br_target  in  32  redirect address, valid with br_taken.
- if_allow_in  in  1  IF stage accepts an instruction this cycle.
- inst_sram_req  out  1  fetch request valid.
- inst_sram_addr  out  32  fetch address (word aligned).
- inst_sram_addr_ok  in  1  request accepted this cycle (meaningful only with req=1).
- inst_sram_data_ok  in  1  read data returned this cycle.
- inst_sram_rdata  in  32  returned instruction.
- if_valid  out  1  buffered instruction available to IF.
- if_pc  out  32  PC of buffered instruction.
- if_inst  out  32  buffered instruction.

Behaviour:
- State register: REQ (request being presented) and WAIT (address accepted, data outstanding).
- Internal registers:
  - fetch_pc: next address to request.
  - req_pc: PC of the outstanding fetch.
  - cancel: outstanding response must be dropped.
  - out_valid/if_pc/if_inst: one-entry output buffer.
- Reset (rst=1 at a posedge):
  - state=REQ, fetch_pc=RESET_PC, cancel=0, if_valid=0, if_pc=0, if_inst=0.
  - inst_sram_req=0 while rst=1. Reset mid-transaction abandons the outstanding fetch; the SRAM side is reset by the same rst.
- consume = if_valid & if_allow_in. The buffer empties on the next edge unless it is refilled in the same cycle.
- REQ state:
  - inst_sram_req = !if_valid | consume; inst_sram_addr = fetch_pc (combinational from registers).
  - On req & addr_ok: req_pc<=fetch_pc, state->WAIT. fetch_pc is not advanced yet.
- WAIT state:
  - inst_sram_req=0.
  - On data_ok with cancel=1: drop the data, cancel<=0, state->REQ.
  - On data_ok with cancel=0: if_inst<=rdata, if_pc<=req_pc, if_valid<=1, fetch_pc<=req_pc+4, state->REQ.
  - The buffer is guaranteed free, because a request is only issued when the buffer is empty or draining.
- Redirect (br_taken=1) has highest priority for fetch_pc and the buffer:
  - fetch_pc<=br_target; if_valid<=0, killing the wrong-path buffered instruction.
  - In WAIT without same-cycle data_ok: cancel<=1.
  - In REQ with same-cycle addr_ok: the request is accepted, cancel<=1, state->WAIT.
  - In REQ without addr_ok: no cancel; the next request uses br_target.
  - In WAIT with same-cycle data_ok (cancel=0): data dropped, state->REQ, fetch_pc=br_target.
  - In WAIT with same-cycle data_ok (cancel=1): cancel<=0, state->REQ, fetch_pc=br_target.
  - Back-to-back redirects: the last one wins; cancel never exceeds one outstanding response.
- Latency: addr_ok to if_valid is data_ok cycle +1. For a zero-wait SRAM (addr_ok same cycle, data_ok next), steady-state throughput is one instruction per 2 cycles.
- PC arithmetic is modulo 2^32 (0xfffffffc+4 = 0). Low two address bits are passed through unchecked; alignment faults are handled downstream.
- data_ok in REQ state is a protocol violation. The RTL asserts on it in simulation and ignores it.

Decomposition:
- Shared package: state encoding (FS_REQ, FS_WAIT), RESET_PC default, PC_INCR=4.
- One natural sub-module: fetch_out_buf, the single-entry valid/pc/inst buffer with fill, consume and kill inputs.
- The FSM and redirect logic stay in fetch_ctrl.

Test Plan:
- Reset release, SRAM addr_ok same cycle, data_ok next cycle, if_allow_in=1 -> req addr 0x1c000000, then 0x1c000004; if_valid with if_pc=0x1c000000.
- if_allow_in=0 after first instruction -> if_valid held, if_pc stable, no new req until if_allow_in=1; no instruction lost or duplicated.
- br_taken target 0x1c000100 while in WAIT -> the returning data_ok for the old PC is dropped (if_valid stays 0); next req addr 0x1c000100.
- br_taken coincident with addr_ok in REQ -> that response is discarded; next accepted addr is the target.
- br_taken coincident with data_ok (cancel=0) while if_valid=1 -> buffered instruction killed, returned data dropped, next addr = target.
- rst asserted in WAIT -> next cycle req=0, if_valid=0; after release first addr = 0x1c000000.
